// File: rtl/mem_stage_ls.sv
// mem_stage_ls: MIPS memory stage with byte/half/word loads and stores,
// a request/ready handshake to a variable-latency data memory, a bounded
// wait with bus-error abort, and the M->W pipeline register.

module mem_stage_ls #(
  parameter int ADDR_W     = 32,
  parameter int REG_W      = 5,
  parameter int MAX_WAIT   = 16,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  WriteRegM,
  input  logic [31:0]       WriteDataM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [1:0]        MemSizeM,
  input  logic              MemSignedM,
  output logic              MemReq,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWD,
  output logic [3:0]        MemBE,
  input  logic [31:0]       MemRD,
  input  logic              MemReady,
  output logic              StallM,
  output logic              MisalignM,
  output logic              BusErrM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [31:0]       ReadDataW,
  output logic [ADDR_W-1:0] ALUOutW,
  output logic [REG_W-1:0]  WriteRegW
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // In WAIT, cnt holds the number of request cycles already spent, so the
  // current cycle is cnt+1 and the last allowed one is reached at MAX_WAIT-1.
  localparam logic [31:0] LAST_CNT = 32'(MAX_WAIT - 1);

  state_t      state, next_state;
  logic [31:0] cnt, next_cnt;

  logic        mem_op, is_load, aligned, complete, w_load;
  logic [1:0]  low_addr, byte_idx;
  logic        half_idx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign low_addr = ALUOutM[1:0];
  assign byte_idx = BIG_ENDIAN ? ~low_addr : low_addr;
  assign half_idx = BIG_ENDIAN ? ~low_addr[1] : low_addr[1];
  assign mem_op   = MemReadM | MemWriteM;
  assign is_load  = MemReadM & ~MemWriteM;
  assign MemAddr  = {ALUOutM[ADDR_W-1:2], 2'b00};
  assign MemWE    = MemReq & MemWriteM;

  // Alignment check, lane enables and replicated store data by access size
  always_comb begin
    aligned = 1'b1;
    MemBE   = 4'b1111;
    MemWD   = WriteDataM;
    case (MemSizeM)
      2'b00: begin
        aligned = 1'b1;
        MemBE   = 4'b0001 << byte_idx;
        MemWD   = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        aligned = ~low_addr[0];
        MemBE   = half_idx ? 4'b1100 : 4'b0011;
        MemWD   = {2{WriteDataM[15:0]}};
      end
      default: begin
        aligned = (low_addr == 2'b00);
        MemBE   = 4'b1111;
        MemWD   = WriteDataM;
      end
    endcase
  end

  // Pick the addressed lane out of the read word and extend it to 32 bits
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    load_data = MemRD;
    case (byte_idx)
      2'd0:    byte_sel = MemRD[7:0];
      2'd1:    byte_sel = MemRD[15:8];
      2'd2:    byte_sel = MemRD[23:16];
      default: byte_sel = MemRD[31:24];
    endcase
    half_sel = half_idx ? MemRD[31:16] : MemRD[15:0];
    case (MemSizeM)
      2'b00:   load_data = {{24{MemSignedM & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{MemSignedM & half_sel[15]}}, half_sel};
      default: load_data = MemRD;
    endcase
  end

  // Handshake FSM: issue, wait for ready, abort after MAX_WAIT request cycles
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    MemReq     = 1'b0;
    StallM     = 1'b0;
    MisalignM  = 1'b0;
    BusErrM    = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        next_cnt = 32'd0;
        if (mem_op) begin
          if (aligned) begin
            MemReq = 1'b1;
            if (MemReady) begin
              complete = 1'b1;
            end else begin
              StallM     = 1'b1;
              next_state = S_WAIT;
              next_cnt   = 32'd1;
            end
          end else begin
            MisalignM = 1'b1;
          end
        end
      end
      default: begin
        MemReq = 1'b1;
        if (MemReady) begin
          complete   = 1'b1;
          next_state = S_IDLE;
          next_cnt   = 32'd0;
        end else if (cnt == LAST_CNT) begin
          BusErrM    = 1'b1;
          next_state = S_IDLE;
          next_cnt   = 32'd0;
        end else begin
          StallM   = 1'b1;
          next_cnt = cnt + 32'd1;
        end
      end
    endcase
    if (reset) begin
      MemReq    = 1'b0;
      StallM    = 1'b0;
      MisalignM = 1'b0;
      BusErrM   = 1'b0;
      complete  = 1'b0;
    end
  end

  // W advances on a finished access or a non-memory op; otherwise a bubble
  assign w_load = complete | ((state == S_IDLE) & ~mem_op);

  // FSM state, wait counter and the M->W pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 32'd0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= 32'd0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (w_load) begin
        RegWriteW <= RegWriteM;
        MemtoRegW <= MemtoRegM;
        ReadDataW <= (is_load && complete) ? load_data : 32'd0;
        ALUOutW   <= ALUOutM;
        WriteRegW <= WriteRegM;
      end else begin
        RegWriteW <= 1'b0;
        MemtoRegW <= 1'b0;
      end
    end
  end

endmodule
